// File: rtl/monobit_engine.sv
// Monobit (frequency) randomness test engine: accumulates N sequence bits in LANES-bit beats and judges |2*ones - N|.
// Optional block-frequency sub-test is compiled in with `define MONOBIT_BLOCK_TEST_EN.
module monobit_engine #(
    parameter int LANES        = 8,
    parameter int LOG2_N       = 10,
    parameter int THRESH       = 82,
    parameter int LOG2_M       = 7,
    parameter int BLK_THRESH   = 32,
    parameter int BLK_FAIL_MAX = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LANES-1:0]           din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [LOG2_N:0]            ones_cnt,
    output logic [LOG2_N:0]            sum_abs,
    output logic [LOG2_N-LOG2_M:0]     blk_fail_cnt
);

    localparam int LOG2_L = $clog2(LANES);
    localparam int N_BITS = 32'd1 << LOG2_N;
    localparam int PC_W   = LOG2_L + 1;
    localparam int CNT_W  = LOG2_N + 1;
    localparam int SUM_W  = LOG2_N + 2;
    localparam int BEAT_W = LOG2_N - LOG2_L + 1;
    localparam int BF_W   = LOG2_N - LOG2_M + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'((32'd1 << (LOG2_N - LOG2_L)) - 32'd1);

    // A misconfigured instance must never report a passing verdict.
    localparam bit CFG_OK = (LANES >= 1) && (LANES <= 8) && ((32'd1 << LOG2_L) == LANES) &&
                            (LOG2_N >= LOG2_L) && (LOG2_M >= LOG2_L) && (LOG2_M <= LOG2_N) &&
                            (THRESH >= 0) && (BLK_THRESH >= 0) && (BLK_FAIL_MAX >= 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    state_t                state_r;
    logic                  busy_r;
    logic                  din_ready_r;
    logic                  done_r;
    logic                  pass_r;
    logic [CNT_W-1:0]      ones_cnt_r;
    logic [CNT_W-1:0]      sum_abs_r;
    logic [CNT_W-1:0]      ones_r;
    logic [BEAT_W-1:0]     beat_r;

    logic                  accept_s;
    logic                  clear_s;
    logic                  last_s;
    logic                  eval_s;
    logic [PC_W-1:0]       pop_s;
    logic signed [SUM_W-1:0] dev_s;
    logic [CNT_W-1:0]      sum_abs_s;
    logic                  blk_ok_s;
    logic                  pass_s;

    // Handshake and phase decodes shared by the datapath blocks.
    always_comb begin
        accept_s = din_valid & din_ready_r;
        clear_s  = (state_r == IDLE) & start;
        last_s   = accept_s & (beat_r == LAST_BEAT);
        eval_s   = (state_r == EVAL);
        pop_s    = popcount(din);
    end

    // Deviation |2*ones - N| in LOG2_N+2-bit signed arithmetic; 2N - N wraps back to +N correctly.
    always_comb begin
        dev_s = $signed({ones_r, 1'b0}) - $signed(SUM_W'(N_BITS));
        if (dev_s[SUM_W-1]) begin
            sum_abs_s = CNT_W'(-dev_s);
        end else begin
            sum_abs_s = CNT_W'(dev_s);
        end
        pass_s = CFG_OK && ({{(32-CNT_W){1'b0}}, sum_abs_s} <= 32'(THRESH)) && blk_ok_s;
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            din_ready_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= ACCUM;
                        busy_r      <= 1'b1;
                        din_ready_r <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        din_ready_r <= 1'b0;
                    end
                end
                ACCUM: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b1;
                    if (last_s) begin
                        state_r     <= EVAL;
                        din_ready_r <= 1'b0;
                    end else begin
                        state_r     <= ACCUM;
                        din_ready_r <= 1'b1;
                    end
                end
                EVAL: begin
                    state_r     <= DONE;
                    busy_r      <= 1'b1;
                    din_ready_r <= 1'b0;
                    done_r      <= 1'b1;
                end
                DONE: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    din_ready_r <= 1'b0;
                    done_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    din_ready_r <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // Ones accumulator and beat counter, cleared when a new test starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_r <= {CNT_W{1'b0}};
            beat_r <= {BEAT_W{1'b0}};
        end else if (clear_s) begin
            ones_r <= {CNT_W{1'b0}};
            beat_r <= {BEAT_W{1'b0}};
        end else if (accept_s) begin
            ones_r <= ones_r + CNT_W'(pop_s);
            beat_r <= beat_r + BEAT_W'(1'b1);
        end else begin
            ones_r <= ones_r;
            beat_r <= beat_r;
        end
    end

`ifdef MONOBIT_BLOCK_TEST_EN
    localparam int BLK_W = LOG2_M + 1;
    localparam logic [BEAT_W-1:0] BLK_MASK = BEAT_W'((32'd1 << (LOG2_M - LOG2_L)) - 32'd1);

    function automatic int blk_dev(input logic [BLK_W-1:0] k);
        int d;
        d = int'({k, 1'b0}) - (32'sd1 <<< LOG2_M);
        return (d < 32'sd0) ? -d : d;
    endfunction

    logic [BLK_W-1:0] blk_ones_r;
    logic [BLK_W-1:0] blk_sum_s;
    logic [BF_W-1:0]  blk_fail_r;
    logic [BF_W-1:0]  blk_fail_cnt_r;
    logic             blk_end_s;
    logic             blk_bad_s;

    // Running block count including the current beat; a block closes on its last beat.
    always_comb begin
        blk_sum_s = blk_ones_r + BLK_W'(pop_s);
        blk_end_s = ((beat_r & BLK_MASK) == BLK_MASK);
        blk_bad_s = (blk_dev(blk_sum_s) > BLK_THRESH);
        blk_ok_s  = ({{(32-BF_W){1'b0}}, blk_fail_r} <= 32'(BLK_FAIL_MAX));
    end

    // Per-block ones and failed-block counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_ones_r <= {BLK_W{1'b0}};
            blk_fail_r <= {BF_W{1'b0}};
        end else if (clear_s) begin
            blk_ones_r <= {BLK_W{1'b0}};
            blk_fail_r <= {BF_W{1'b0}};
        end else if (accept_s && blk_end_s) begin
            blk_ones_r <= {BLK_W{1'b0}};
            blk_fail_r <= blk_bad_s ? (blk_fail_r + BF_W'(1'b1)) : blk_fail_r;
        end else if (accept_s) begin
            blk_ones_r <= blk_sum_s;
            blk_fail_r <= blk_fail_r;
        end else begin
            blk_ones_r <= blk_ones_r;
            blk_fail_r <= blk_fail_r;
        end
    end

    // Published failed-block count, updated with the other results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_fail_cnt_r <= {BF_W{1'b0}};
        end else if (eval_s) begin
            blk_fail_cnt_r <= blk_fail_r;
        end else begin
            blk_fail_cnt_r <= blk_fail_cnt_r;
        end
    end

    assign blk_fail_cnt = blk_fail_cnt_r;
`else
    assign blk_ok_s     = 1'b1;
    assign blk_fail_cnt = {BF_W{1'b0}};
`endif

    // Result registers: loaded once per test on the EVAL->DONE edge and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_r <= {CNT_W{1'b0}};
            sum_abs_r  <= {CNT_W{1'b0}};
            pass_r     <= 1'b0;
        end else if (eval_s) begin
            ones_cnt_r <= ones_r;
            sum_abs_r  <= sum_abs_s;
            pass_r     <= pass_s;
        end else begin
            ones_cnt_r <= ones_cnt_r;
            sum_abs_r  <= sum_abs_r;
            pass_r     <= pass_r;
        end
    end

    assign din_ready = din_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign ones_cnt  = ones_cnt_r;
    assign sum_abs   = sum_abs_r;

endmodule
